// File: rtl/stack_controller.sv
// Command-driven stack engine in front of the 128x8 stack RAM.
// The top-of-stack lives in a register so the display path never waits on the RAM.
module stack_controller #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic [DW-1:0] top,
  output logic [7:0]    depth,
  output logic          empty,
  output logic          full,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, PUSH_WR, POP_RD, POP_LD, OP_RD, OP_EX, OP_WR
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;
  localparam logic [7:0] FULL_COUNT = 8'(DEPTH);

  state_t        state, next_state;
  logic [7:0]    depth_q, depth_d;
  logic [DW-1:0] top_q, top_d;
  logic          err_q, err_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] alu_res;
  logic [AW-1:0] addr_below;

  // opnd_q holds the PUSH value and later the binary-op result
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      depth_q <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      opnd_q  <= '0;
      op_q    <= OP_NOP;
    end else begin
      state   <= next_state;
      depth_q <= depth_d;
      top_q   <= top_d;
      err_q   <= err_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
    end
  end

  // mem_data_out holds operand B (second from top) while in OP_EX
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = mem_data_out + top_q;
      OP_SUB:  alu_res = mem_data_out - top_q;
      OP_AND:  alu_res = mem_data_out & top_q;
      OP_OR:   alu_res = mem_data_out | top_q;
      default: alu_res = '0;
    endcase
  end

  assign addr_below = AW'(depth_q - 8'd2);

  always_comb begin
    next_state  = state;
    depth_d     = depth_q;
    top_d       = top_q;
    err_d       = err_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: err_d = 1'b0;
            OP_PUSH: begin
              if (depth_q == FULL_COUNT) begin
                err_d = 1'b1;
              end else begin
                err_d      = 1'b0;
                opnd_d     = cmd_data;
                next_state = PUSH_WR;
              end
            end
            OP_POP: begin
              if (depth_q == 8'd0) begin
                err_d = 1'b1;
              end else if (depth_q == 8'd1) begin
                err_d   = 1'b0;
                depth_d = '0;
                top_d   = '0;
              end else begin
                err_d      = 1'b0;
                next_state = POP_RD;
              end
            end
            OP_CLEAR: begin
              err_d   = 1'b0;
              depth_d = '0;
              top_d   = '0;
            end
            default: begin
              if (depth_q < 8'd2) begin
                err_d = 1'b1;
              end else begin
                err_d      = 1'b0;
                op_d       = cmd_op;
                next_state = OP_RD;
              end
            end
          endcase
        end
      end
      PUSH_WR: begin
        mem_cs      = 1'b1;
        mem_we      = 1'b1;
        mem_address = AW'(depth_q);
        mem_data_in = opnd_q;
        depth_d     = depth_q + 8'd1;
        top_d       = opnd_q;
        next_state  = IDLE;
      end
      POP_RD: begin
        mem_cs      = 1'b1;
        mem_address = addr_below;
        next_state  = POP_LD;
      end
      POP_LD: begin
        top_d      = mem_data_out;
        depth_d    = depth_q - 8'd1;
        next_state = IDLE;
      end
      OP_RD: begin
        mem_cs      = 1'b1;
        mem_address = addr_below;
        next_state  = OP_EX;
      end
      OP_EX: begin
        opnd_d     = alu_res;
        next_state = OP_WR;
      end
      OP_WR: begin
        mem_cs      = 1'b1;
        mem_we      = 1'b1;
        mem_address = addr_below;
        mem_data_in = opnd_q;
        depth_d     = depth_q - 8'd1;
        top_d       = opnd_q;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign top   = top_q;
  assign depth = depth_q;
  assign empty = (depth_q == 8'd0);
  assign full  = (depth_q == FULL_COUNT);
  assign busy  = (state != IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a negedge-sampled 128x8 RAM model.
// A vector table covers the command set; hand sequences cover fill, busy and reset corners.
module tb_stack_controller;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       mem_cs;
  logic       mem_we;
  logic [6:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic [7:0] top;
  logic [7:0] depth;
  logic       empty;
  logic       full;
  logic       busy;
  logic       err;

  stack_controller #(.DEPTH(128), .AW(7), .DW(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .top(top), .depth(depth), .empty(empty),
    .full(full), .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model plus access counters, reset at the start of every command
  logic [7:0] ram [128];
  int csCount;
  int weCount;
  int lastAddr;
  int lastWdata;

  always @(negedge clock) begin
    if (mem_cs) begin
      csCount  = csCount + 1;
      lastAddr = int'(mem_address);
      if (mem_we) begin
        weCount   = weCount + 1;
        lastWdata = int'(mem_data_in);
        ram[mem_address] = mem_data_in;
      end else begin
        mem_data_out = ram[mem_address];
      end
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    int         expTop;
    int         expDepth;
    int         expErr;
    int         expBusy;
    int         expCs;
    int         expWe;
    int         expAddr;
    int         expWdata;
  } vec_t;

  vec_t vecs [27];
  int testsRun;
  int failCount;

  function automatic vec_t mk(input int op, input int data, input int t, input int d,
                              input int e, input int b, input int cs, input int we,
                              input int addr, input int wd);
    vec_t v;
    v.op = 3'(op); v.data = 8'(data); v.expTop = t; v.expDepth = d; v.expErr = e;
    v.expBusy = b; v.expCs = cs; v.expWe = we; v.expAddr = addr; v.expWdata = wd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one command for exactly one sampling edge; returns #1 after that edge
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
    csCount = 0;
    weCount = 0;
    lastAddr = -1;
    lastWdata = -1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'b000;
    cmd_data = 8'h00;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles = cycles + 1;
    end
  endtask

  task automatic runCmd(input logic [2:0] op, input logic [7:0] data);
    int cyc;
    applyStimulus(op, data);
    waitIdle(cyc);
    checkOutput("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    testsRun = 0;
    failCount = 0;
    csCount = 0;
    weCount = 0;
    lastAddr = -1;
    lastWdata = -1;
    mem_data_out = 8'h00;
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;

    vecs[0]  = mk(1, 'h12, 'h12, 1, 0, 1, 1, 1, 0, 'h12);
    vecs[1]  = mk(1, 'h34, 'h34, 2, 0, 1, 1, 1, 1, 'h34);
    vecs[2]  = mk(7, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    vecs[3]  = mk(1, 'h05, 'h05, 1, 0, 1, 1, 1, 0, 'h05);
    vecs[4]  = mk(1, 'h07, 'h07, 2, 0, 1, 1, 1, 1, 'h07);
    vecs[5]  = mk(4, 0, 'hFE, 1, 0, 3, 2, 1, 0, 'hFE);
    vecs[6]  = mk(7, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    vecs[7]  = mk(1, 'h80, 'h80, 1, 0, 1, 1, 1, 0, 'h80);
    vecs[8]  = mk(1, 'h90, 'h90, 2, 0, 1, 1, 1, 1, 'h90);
    vecs[9]  = mk(3, 0, 'h10, 1, 0, 3, 2, 1, 0, 'h10);
    vecs[10] = mk(5, 0, 'h10, 1, 1, 0, 0, 0, -1, 0);
    vecs[11] = mk(0, 0, 'h10, 1, 0, 0, 0, 0, -1, 0);
    vecs[12] = mk(7, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    vecs[13] = mk(1, 'hAA, 'hAA, 1, 0, 1, 1, 1, 0, 'hAA);
    vecs[14] = mk(1, 'hBB, 'hBB, 2, 0, 1, 1, 1, 1, 'hBB);
    vecs[15] = mk(1, 'hCC, 'hCC, 3, 0, 1, 1, 1, 2, 'hCC);
    vecs[16] = mk(2, 0, 'hBB, 2, 0, 2, 1, 0, 1, 0);
    vecs[17] = mk(2, 0, 'hAA, 1, 0, 2, 1, 0, 0, 0);
    vecs[18] = mk(2, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    vecs[19] = mk(2, 0, 0, 0, 1, 0, 0, 0, -1, 0);
    vecs[20] = mk(1, 'h0F, 'h0F, 1, 0, 1, 1, 1, 0, 'h0F);
    vecs[21] = mk(1, 'hF0, 'hF0, 2, 0, 1, 1, 1, 1, 'hF0);
    vecs[22] = mk(6, 0, 'hFF, 1, 0, 3, 2, 1, 0, 'hFF);
    vecs[23] = mk(1, 'h3C, 'h3C, 2, 0, 1, 1, 1, 1, 'h3C);
    vecs[24] = mk(5, 0, 'h3C, 1, 0, 3, 2, 1, 0, 'h3C);
    vecs[25] = mk(4, 0, 'h3C, 1, 1, 0, 0, 0, -1, 0);
    vecs[26] = mk(7, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'b000;
    cmd_data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_top", int'(top), 0);
    checkOutput("rst_depth", int'(depth), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_cs", int'(mem_cs), 0);
    checkOutput("rst_we", int'(mem_we), 0);
    checkOutput("rst_addr", int'(mem_address), 0);
    checkOutput("rst_wdata", int'(mem_data_in), 0);

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data);
      checkOutput($sformatf("v%0d_err", i), int'(err), vecs[i].expErr);
      waitIdle(cyc);
      checkOutput($sformatf("v%0d_busy", i), cyc, vecs[i].expBusy);
      checkOutput($sformatf("v%0d_top", i), int'(top), vecs[i].expTop);
      checkOutput($sformatf("v%0d_depth", i), int'(depth), vecs[i].expDepth);
      checkOutput($sformatf("v%0d_empty", i), int'(empty), (vecs[i].expDepth == 0) ? 1 : 0);
      checkOutput($sformatf("v%0d_cs", i), csCount, vecs[i].expCs);
      checkOutput($sformatf("v%0d_we", i), weCount, vecs[i].expWe);
      if (vecs[i].expAddr >= 0)
        checkOutput($sformatf("v%0d_addr", i), lastAddr, vecs[i].expAddr);
      if (vecs[i].expWe > 0)
        checkOutput($sformatf("v%0d_wdata", i), lastWdata, vecs[i].expWdata);
    end

    // Fill to capacity, then overflow
    for (int i = 0; i < 127; i++) runCmd(3'b001, 8'(i));
    checkOutput("fill127_depth", int'(depth), 127);
    checkOutput("fill127_full", int'(full), 0);
    runCmd(3'b001, 8'h7F);
    checkOutput("fill128_addr", lastAddr, 127);
    checkOutput("fill128_wdata", lastWdata, 'h7F);
    checkOutput("fill128_full", int'(full), 1);
    checkOutput("fill128_top", int'(top), 'h7F);
    checkOutput("fill128_depth", int'(depth), 128);
    applyStimulus(3'b001, 8'h99);
    checkOutput("ovf_err", int'(err), 1);
    checkOutput("ovf_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    checkOutput("ovf_we", weCount, 0);
    checkOutput("ovf_cs", csCount, 0);
    checkOutput("ovf_depth", int'(depth), 128);
    applyStimulus(3'b000, 8'h00);
    checkOutput("nop_err", int'(err), 0);
    runCmd(3'b010, 8'h00);
    checkOutput("pop128_addr", lastAddr, 126);
    checkOutput("pop128_top", int'(top), 'h7E);
    checkOutput("pop128_depth", int'(depth), 127);
    runCmd(3'b011, 8'h00);
    checkOutput("add127_top", int'(top), 'hFB);
    checkOutput("add127_addr", lastAddr, 125);
    checkOutput("add127_depth", int'(depth), 126);

    // Commands presented while busy must be dropped
    runCmd(3'b111, 8'h00);
    runCmd(3'b001, 8'h21);
    runCmd(3'b001, 8'h22);
    applyStimulus(3'b011, 8'h00);
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    cmd_data = 8'h55;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'b000;
    waitIdle(cyc);
    checkOutput("busyign_top", int'(top), 'h43);
    checkOutput("busyign_depth", int'(depth), 1);
    checkOutput("busyign_we", weCount, 1);
    checkOutput("busyign_err", int'(err), 0);

    // Reset while the binary op sits in OP_EX
    runCmd(3'b111, 8'h00);
    runCmd(3'b001, 8'h03);
    runCmd(3'b001, 8'h04);
    applyStimulus(3'b011, 8'h00);
    @(posedge clock);
    #1;
    checkOutput("opex_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("midrst_depth", int'(depth), 0);
    checkOutput("midrst_top", int'(top), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_cs", int'(mem_cs), 0);
    @(posedge clock);
    #1;
    checkOutput("midrst_we", weCount, 0);
    checkOutput("midrst_empty", int'(empty), 1);
    runCmd(3'b001, 8'h66);
    checkOutput("postrst_addr", lastAddr, 0);
    checkOutput("postrst_top", int'(top), 'h66);
    checkOutput("postrst_depth", int'(depth), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
